rx2in_ctl: RTL and testbench

//  Receive-side counterpart of the outbox-to-TX pop controller. Sits between the

---
 rtl/rx2in_ctl_if.sv | 26 ++
 rtl/rx2in_ctl.sv | 112 +++++++++++
 tb/tb_rx2in_ctl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx2in_ctl_if.sv
// Byte path between the UART receiver, the RX-to-INBOX controller and the CPU INBOX.
interface rx2in_ctl_if;
    logic       i_rx_wr;
    logic [7:0] i_rx_data;
    logic       i_full;
    logic       o_in_wr;
    logic [7:0] o_in_data;

    // Environment side: drives the RX strobe/data and INBOX full, observes INBOX writes.
    modport master (
        output i_rx_wr,
        output i_rx_data,
        output i_full,
        input  o_in_wr,
        input  o_in_data
    );

    // Controller side.
    modport slave (
        input  i_rx_wr,
        input  i_rx_data,
        input  i_full,
        output o_in_wr,
        output o_in_data
    );
endinterface

// File: rtl/rx2in_ctl.sv
// RX-to-INBOX controller: buffers UART RX bytes in a small FIFO and writes them to the
// CPU INBOX while it is not full. RX has no backpressure, so bytes arriving with no free
// slot are dropped and counted.
module rx2in_ctl #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_rst_n,
    rx2in_ctl_if.slave        bus,
    input  logic              i_clr_ovf,
    output logic [ADDR_W:0]   o_level,
    output logic              o_overflow,
    output logic [7:0]        o_drop_cnt
);

    localparam logic [ADDR_W:0] LevelMax = DEPTH[ADDR_W:0];

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              in_wr_q, in_wr_d;
    logic [7:0]        in_data_q, in_data_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic pop, push, drop;

    // Pop waits one cycle after each write so the INBOX full flag can catch up.
    always_comb begin
        pop  = (level_q != '0) && !bus.i_full && !in_wr_q;
        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        push = bus.i_rx_wr && ((level_q < LevelMax) || pop);
        drop = bus.i_rx_wr && !push;
    end

    // Next-state for pointers, level, INBOX write port and drop bookkeeping.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        in_wr_d    = 1'b0;
        in_data_d  = in_data_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (pop) begin
            in_wr_d   = 1'b1;
            in_data_d = mem_q[rptr_q];
            rptr_d    = rptr_q + ADDR_W'(1);
        end
        if (push) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        // Clear wins, except that a drop on the same edge is counted as the first new one.
        if (i_clr_ovf && drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = 8'd1;
        end else if (i_clr_ovf) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            in_wr_q    <= 1'b0;
            in_data_q  <= 8'd0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            in_wr_q    <= in_wr_d;
            in_data_q  <= in_data_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.i_rx_data;
        end
    end

    assign bus.o_in_wr   = in_wr_q;
    assign bus.o_in_data = in_data_q;
    assign o_level       = level_q;
    assign o_overflow    = ovf_q;
    assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_rx2in_ctl.sv
// Bench for rx2in_ctl: hand-computed vector table plus directed multi-cycle sequences
// checked cycle by cycle against a small behavioural model.
module tb_rx2in_ctl;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_clr_ovf;
    logic [4:0] o_level;
    logic       o_overflow;
    logic [7:0] o_drop_cnt;

    rx2in_ctl_if bus ();

    rx2in_ctl #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .bus        (bus),
        .i_clr_ovf  (i_clr_ovf),
        .o_level    (o_level),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int         m_lvl;
    bit         m_inwr;
    logic [7:0] m_data;
    bit         m_ovf;
    int         m_cnt;
    int         m_drops;
    logic [7:0] q[$];

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       full;
        logic       clr;
        logic       e_wr;
        logic [7:0] e_data;
        int         e_lvl;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [7:0] d, input logic full,
                         input logic clr);
        bus.i_rx_wr   = wr;
        bus.i_rx_data = d;
        bus.i_full    = full;
        i_clr_ovf     = clr;
    endtask

    // One clock with model update and full output comparison.
    task automatic mcyc(input logic wr, input logic [7:0] d, input logic full,
                        input logic clr);
        bit pop, push, drop;
        drive(wr, d, full, clr);
        pop  = (m_lvl != 0) && !full && !m_inwr;
        push = wr && ((m_lvl < 16) || pop);
        drop = wr && !push;
        if (pop) begin
            m_inwr = 1'b1;
            m_data = q.pop_front();
        end else begin
            m_inwr = 1'b0;
        end
        if (push) q.push_back(d);
        m_lvl = q.size();
        if (drop) m_drops++;
        if (clr && drop) begin
            m_ovf = 1'b1;
            m_cnt = 1;
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        step();
        chk("in_wr", 32'(bus.o_in_wr), 32'(m_inwr));
        chk("in_data", 32'(bus.o_in_data), 32'(m_data));
        chk("level", 32'(o_level), 32'(m_lvl));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(o_drop_cnt), 32'(m_cnt));
    endtask

    // Run idle cycles with INBOX not full until the model says the FIFO has drained.
    task automatic drain();
        int n = 0;
        while ((m_lvl != 0 || m_inwr) && n < 100) begin
            mcyc(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("drain_done", 32'(o_level), 32'd0);
        if (n >= 100) begin
            errors++;
            $display("FAIL drain_timeout: level 0x%0h after %0d cycles", o_level, n);
        end
    endtask

    task automatic model_reset();
        m_lvl   = 0;
        m_inwr  = 1'b0;
        m_data  = 8'h00;
        m_ovf   = 1'b0;
        m_cnt   = 0;
        m_drops = 0;
        q.delete();
    endtask

    initial begin
        // {wr, data, full, clr, exp in_wr, exp in_data, exp level}
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        tbl[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h41, 0};
        tbl[4]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h41, 1};
        tbl[5]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1};
        tbl[6]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 8'hA1, 2};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA1, 2};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA2, 1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA2, 1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA3, 0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA3, 0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA3, 0};

        // Test 1: reset held 3 cycles, then table of short transactions.
        i_rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_wr", 32'(bus.o_in_wr), 32'd0);
        chk("rst_in_data", 32'(bus.o_in_data), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_cnt", 32'(o_drop_cnt), 32'd0);
        i_rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].wr, tbl[i].d, tbl[i].full, tbl[i].clr);
            step();
            chk($sformatf("vec%0d_in_wr", i), 32'(bus.o_in_wr), 32'(tbl[i].e_wr));
            chk($sformatf("vec%0d_in_data", i), 32'(bus.o_in_data), 32'(tbl[i].e_data));
            chk($sformatf("vec%0d_level", i), 32'(o_level), 32'(tbl[i].e_lvl));
            chk($sformatf("vec%0d_ovf", i), 32'(o_overflow), 32'd0);
            chk($sformatf("vec%0d_cnt", i), 32'(o_drop_cnt), 32'd0);
        end

        model_reset();
        m_data = 8'hA3;

        // Test 2: INBOX full, fill FIFO then overflow by two.
        for (int i = 0; i < 16; i++) mcyc(1'b1, 8'(i), 1'b1, 1'b0);
        chk("t2_level16", 32'(o_level), 32'd16);
        mcyc(1'b1, 8'h10, 1'b1, 1'b0);
        mcyc(1'b1, 8'h11, 1'b1, 1'b0);
        chk("t2_ovf", 32'(o_overflow), 32'd1);
        chk("t2_cnt", 32'(o_drop_cnt), 32'd2);
        chk("t2_level", 32'(o_level), 32'd16);

        // Test 3: release INBOX, 16 pulses two cycles apart in order.
        for (int i = 0; i < 32; i++) begin
            mcyc(1'b0, 8'h00, 1'b0, 1'b0);
            chk("t3_pulse", 32'(bus.o_in_wr), 32'((i % 2) == 0));
            if ((i % 2) == 0) chk("t3_data", 32'(bus.o_in_data), 32'(i / 2));
        end
        chk("t3_level", 32'(o_level), 32'd0);
        chk("t3_ovf", 32'(o_overflow), 32'd1);

        // Test 4: full FIFO with a pop pending accepts a push on the pop edge.
        for (int i = 0; i < 16; i++) mcyc(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
        mcyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("t4_in_wr", 32'(bus.o_in_wr), 32'd1);
        chk("t4_data", 32'(bus.o_in_data), 32'hB0);
        chk("t4_level", 32'(o_level), 32'd16);
        chk("t4_cnt", 32'(o_drop_cnt), 32'd2);
        drain();
        chk("t4_last", 32'(bus.o_in_data), 32'hEE);

        // Test 5: saturation, clear colliding with a drop, then plain clear.
        for (int i = 0; i < 16; i++) mcyc(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) mcyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("t5_sat", 32'(o_drop_cnt), 32'd255);
        mcyc(1'b1, 8'h56, 1'b1, 1'b1);
        chk("t5_clr_drop_ovf", 32'(o_overflow), 32'd1);
        chk("t5_clr_drop_cnt", 32'(o_drop_cnt), 32'd1);
        mcyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("t5_clr_ovf", 32'(o_overflow), 32'd0);
        chk("t5_clr_cnt", 32'(o_drop_cnt), 32'd0);
        drain();

        // Test 6: 40 bytes at full rate with INBOX full toggling; pointers wrap.
        m_drops = 0;
        for (int i = 0; i < 40; i++) mcyc(1'b1, 8'h60 + 8'(i), 1'($urandom % 2), 1'b0);
        drain();
        chk("t6_drops", 32'(o_drop_cnt), 32'(m_drops));
        chk("t6_queue_empty", 32'(q.size()), 32'd0);

        // Async reset mid-stream clears outputs without waiting for a clock edge.
        for (int i = 0; i < 3; i++) mcyc(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0);
        mcyc(1'b1, 8'h93, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_in_wr", 32'(bus.o_in_wr), 32'd0);
        chk("arst_in_data", 32'(bus.o_in_data), 32'd0);
        chk("arst_level", 32'(o_level), 32'd0);
        chk("arst_ovf", 32'(o_overflow), 32'd0);
        chk("arst_cnt", 32'(o_drop_cnt), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        i_rst_n = 1'b1;
        model_reset();
        mcyc(1'b0, 8'h00, 1'b0, 1'b0);
        mcyc(1'b1, 8'h7E, 1'b0, 1'b0);
        drain();
        chk("post_rst_data", 32'(bus.o_in_data), 32'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
